// File: rtl/block_memory_wb.sv
// block_memory_wb: single-port backing data memory behind the data cache, with a write buffer.
//
// Serves block reads (cache line fills) after READ_LATENCY cycles. Write-through stores go
// into a circular write buffer that drains one word every WRITE_LATENCY cycles. A combined
// store-miss (ReadMiss with MemWriteThrough) returns the block with the stored word merged
// and commits that word when the block is loaded.
//
// Ports:
//   Clk             clock; all state changes on the rising edge
//   Rst             asynchronous active-low reset
//   Address         byte address of the read block or the write word
//   ReadMiss        block read request; level, held until ReadReady
//   MemWriteThrough word write request
//   Write_data      word to write
//   Read_data       returned block; word i at bits [32i+31:32i]
//   ReadReady       one-cycle pulse; Read_data valid
//   WriteReady      one-cycle pulse; the write was accepted into the buffer
//   WriteBufFull    buffer holds WB_DEPTH entries
//   Busy            read engine not idle, or buffer not empty
//
// Build option: define READ_BYPASS_EN to let a read skip the drain wait. Buffered entries
// that fall in the block are then forwarded into the returned data (youngest wins), and
// the drain keeps running while the read waits.

module block_memory_wb #(
  parameter int unsigned ROWS          = 64,
  parameter int unsigned BLOCK_SIZE    = 4,
  parameter int unsigned READ_LATENCY  = 20,
  parameter int unsigned WRITE_LATENCY = 20,
  parameter int unsigned WB_DEPTH      = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [31:0]             Address,
  input  logic                    ReadMiss,
  input  logic                    MemWriteThrough,
  input  logic [31:0]             Write_data,
  output logic [32*BLOCK_SIZE-1:0] Read_data,
  output logic                    ReadReady,
  output logic                    WriteReady,
  output logic                    WriteBufFull,
  output logic                    Busy
);

  localparam int unsigned IW     = $clog2(ROWS);
  localparam int unsigned PW     = $clog2(WB_DEPTH);
  localparam int unsigned MaxLat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CW     = $clog2(MaxLat + 1);
`ifdef READ_BYPASS_EN
  // No RD_HOLD cycle, so the whole latency is spent in RD_WAIT.
  localparam int unsigned WaitLast = READ_LATENCY - 1;
`else
  // One cycle of the latency is spent in RD_HOLD.
  localparam int unsigned WaitLast = READ_LATENCY - 2;
`endif
  localparam logic [IW-1:0] BlkMask    = IW'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0] WaitLastC  = CW'(WaitLast);
  localparam logic [CW-1:0] DrainLastC = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRdHold, StRdWait, StRdReady} state_e;

  // Request decode
  logic [IW-1:0] req_idx, req_base;
  logic          unused_addr;
  assign req_idx     = Address[IW+1:2];
  assign req_base    = req_idx & ~BlkMask;
  assign unused_addr = ^{Address[31:IW+2], Address[1:0]};

  // Storage
  logic [31:0]   mem     [ROWS];
  logic [IW-1:0] wb_idx  [WB_DEPTH];
  logic [31:0]   wb_data [WB_DEPTH];

  // Write buffer and drain engine state
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          wb_empty, wb_full, wb_push, wb_pop, drain_run;

  // Read engine state
  state_e                  state_q, state_d;
  logic [CW-1:0]           rcnt_q, rcnt_d;
  logic [IW-1:0]           base_q, base_d;
  logic                    merge_q, merge_d;
  logic [IW-1:0]           midx_q, midx_d;
  logic [31:0]             mdata_q, mdata_d;
  logic [32*BLOCK_SIZE-1:0] rdata_q, rdata_d;
  logic                    rready_q, rready_d;
  logic                    wready_q;
  logic                    load;

  logic [31:0]             blk [BLOCK_SIZE];
  logic [32*BLOCK_SIZE-1:0] blk_flat;

  // Write buffer / drain next state
  always_comb begin
    wb_empty = (count_q == '0);
    wb_full  = (count_q == (PW+1)'(WB_DEPTH));
    wb_push  = MemWriteThrough && !ReadMiss && !wb_full;
`ifdef READ_BYPASS_EN
    drain_run = !wb_empty;
`else
    // Memory port belongs to the read while it waits.
    drain_run = !wb_empty && (state_q != StRdWait);
`endif
    wb_pop = drain_run && (dcnt_q == DrainLastC);

    dcnt_d = dcnt_q;
    if (drain_run) begin
      dcnt_d = wb_pop ? '0 : dcnt_q + CW'(1);
    end

    head_d = wb_pop  ? head_q + PW'(1) : head_q;
    tail_d = wb_push ? tail_q + PW'(1) : tail_q;

    count_d = count_q;
    if (wb_push && !wb_pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!wb_push && wb_pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // Block assembly: memory words, then forwarded buffer entries, then the merge word.
  always_comb begin
    for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
      blk[i] = mem[base_q + IW'(i)];
    end
`ifdef READ_BYPASS_EN
    // Oldest to youngest so the youngest matching entry wins.
    for (int k = 0; k < int'(WB_DEPTH); k++) begin
      if (((PW+1)'(k) < count_q) && ((wb_idx[head_q + PW'(k)] & ~BlkMask) == base_q)) begin
        for (int j = 0; j < int'(BLOCK_SIZE); j++) begin
          if ((wb_idx[head_q + PW'(k)] & BlkMask) == IW'(j)) begin
            blk[j] = wb_data[head_q + PW'(k)];
          end
        end
      end
    end
`endif
    if (merge_q) begin
      for (int j = 0; j < int'(BLOCK_SIZE); j++) begin
        if ((midx_q & BlkMask) == IW'(j)) begin
          blk[j] = mdata_q;
        end
      end
    end
    blk_flat = '0;
    for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
      blk_flat[32*i +: 32] = blk[i];
    end
  end

  // Read engine next state
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    base_d   = base_q;
    merge_d  = merge_q;
    midx_d   = midx_q;
    mdata_d  = mdata_q;
    rdata_d  = rdata_q;
    rready_d = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ReadMiss) begin
          base_d  = req_base;
          merge_d = MemWriteThrough;
          if (MemWriteThrough) begin
            midx_d  = req_idx;
            mdata_d = Write_data;
          end
          rcnt_d = '0;
`ifdef READ_BYPASS_EN
          state_d = StRdWait;
`else
          state_d = StRdHold;
`endif
        end
      end
      StRdHold: begin
        // Read-after-write ordering: wait until every buffered store is in memory.
        rcnt_d = '0;
        if (wb_empty) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (rcnt_q == WaitLastC) begin
          load     = 1'b1;
          rdata_d  = blk_flat;
          rready_d = 1'b1;
          rcnt_d   = '0;
          state_d  = StRdReady;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      StRdReady: begin
        merge_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= StIdle;
      rcnt_q   <= '0;
      base_q   <= '0;
      merge_q  <= 1'b0;
      midx_q   <= '0;
      mdata_q  <= '0;
      rdata_q  <= '0;
      rready_q <= 1'b0;
      wready_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      base_q   <= base_d;
      merge_q  <= merge_d;
      midx_q   <= midx_d;
      mdata_q  <= mdata_d;
      rdata_q  <= rdata_d;
      rready_q <= rready_d;
      wready_q <= wb_push;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Buffer payload: no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge Clk) begin
    if (wb_push) begin
      wb_idx[tail_q]  <= req_idx;
      wb_data[tail_q] <= Write_data;
    end
  end

  // Memory is never cleared. The merge write is issued last so it wins a same-word clash.
  always_ff @(posedge Clk) begin
    if (wb_pop) begin
      mem[wb_idx[head_q]] <= wb_data[head_q];
    end
    if (load && merge_q) begin
      mem[midx_q] <= mdata_q;
    end
  end

  assign Read_data    = rdata_q;
  assign ReadReady    = rready_q;
  assign WriteReady   = wready_q;
  assign WriteBufFull = wb_full;
  assign Busy         = (state_q != StIdle) || !wb_empty;

endmodule

// File: tb/tb_block_memory_wb.sv
module tb_block_memory_wb;
  localparam int unsigned ROWS = 64;
  localparam int unsigned BS   = 4;
  localparam int unsigned RL   = 20;
  localparam int unsigned WL   = 20;
  localparam int unsigned WBD  = 4;
  localparam int unsigned BW   = 32 * BS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   address = '0;
  logic          read_miss = 1'b0;
  logic          mwt = 1'b0;
  logic [31:0]   wdata = '0;
  logic [BW-1:0] read_data;
  logic          read_ready, write_ready, wb_full, busy;

  block_memory_wb #(
    .ROWS(ROWS), .BLOCK_SIZE(BS), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WB_DEPTH(WBD)
  ) dut (
    .Clk(clk), .Rst(rst_n), .Address(address), .ReadMiss(read_miss),
    .MemWriteThrough(mwt), .Write_data(wdata), .Read_data(read_data),
    .ReadReady(read_ready), .WriteReady(write_ready), .WriteBufFull(wb_full), .Busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0]   model [ROWS];
  logic [BW-1:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    bit          merge;
    logic [31:0] wd;
    int          exp_lat;
    logic [31:0] exp_word;
  } rd_vec_t;
  rd_vec_t vecs [5];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out, got no handshake, want one", name);
  endtask

  function automatic logic [31:0] pat(input int i);
    if (i >= 4 && i <= 7) return 32'(32'h11 * (i - 3));
    return 32'h5A00_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) & 32'(ROWS - 1));
  endfunction

  function automatic logic [BW-1:0] model_block(input logic [31:0] a);
    logic [BW-1:0] b;
    int base;
    base = word_idx(a) & ~int'(BS - 1);
    for (int i = 0; i < int'(BS); i++) b[32*i +: 32] = model[base + i];
    return b;
  endfunction

  // Scoreboard: every ReadReady pops the block expected at request time.
  always @(negedge clk) begin
    if (rst_n && read_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_readready: got pulse, want none");
      end else begin
        chk("read_data", read_data, exp_q.pop_front());
      end
    end
  end

  // All tasks are entered on a falling edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit upd);
    int n;
    address = a; wdata = d; mwt = 1'b1; read_miss = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!write_ready && n < 500);
    mwt = 1'b0;
    if (!write_ready) timeout("write_ready");
    if (upd) model[word_idx(a)] = d;
  endtask

  task automatic do_read(input logic [31:0] a, input bit merge, input logic [31:0] d,
                         input int exp_lat, input string name);
    int lat;
    bit done, saw_wr;
    if (merge) model[word_idx(a)] = d;
    exp_q.push_back(model_block(a));
    address = a; read_miss = 1'b1; mwt = merge; wdata = d;
    @(posedge clk);
    lat = 0; done = 0; saw_wr = 0;
    while (!done && lat < 500) begin
      @(negedge clk);
      if (write_ready) saw_wr = 1;
      if (read_ready) done = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    read_miss = 1'b0; mwt = 1'b0;
    if (!done) timeout({name, "_readready"});
    else chk({name, "_latency"}, BW'(lat), BW'(exp_lat));
    chk({name, "_no_writeready"}, BW'(saw_wr), '0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout("wait_idle");
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_read_data"}, read_data, '0);
    chk({tag, "_readready"}, BW'(read_ready), '0);
    chk({tag, "_writeready"}, BW'(write_ready), '0);
    chk({tag, "_wbfull"}, BW'(wb_full), '0);
    chk({tag, "_busy"}, BW'(busy), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, off;
    logic [31:0] old [5];

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Preload all of memory through the write buffer.
    for (int i = 0; i < int'(ROWS); i++) do_write(32'(4 * i), pat(i), 1'b1);
    wait_idle();

    vecs[0] = '{32'h10,  1'b0, 32'h0,    RL, 32'h11};
    vecs[1] = '{32'h1C,  1'b0, 32'h0,    RL, 32'h44};
    vecs[2] = '{32'hFC,  1'b0, 32'h0,    RL, pat(63)};
    vecs[3] = '{32'h100, 1'b0, 32'h0,    RL, pat(0)};
    vecs[4] = '{32'h28,  1'b1, 32'hCAFE, RL, 32'hCAFE};
    for (int v = 0; v < 5; v++) begin
      do_read(vecs[v].addr, vecs[v].merge, vecs[v].wd, vecs[v].exp_lat, $sformatf("vec%0d", v));
      off = word_idx(vecs[v].addr) & int'(BS - 1);
      chk($sformatf("vec%0d_word", v), BW'(read_data[32*off +: 32]), BW'(vecs[v].exp_word));
      wait_idle();
    end
    chk("merge_mem10", BW'(dut.mem[10]), BW'(32'hCAFE));

    // Read-after-write: the read waits for the buffered store to commit.
    do_write(32'h14, 32'hBEEF, 1'b1);
`ifdef READ_BYPASS_EN
    do_read(32'h10, 1'b0, 32'h0, RL, "raw");
`else
    do_read(32'h10, 1'b0, 32'h0, WL + RL - 1, "raw");
`endif
    chk("raw_word1", BW'(read_data[63:32]), BW'(32'hBEEF));
    wait_idle();

`ifdef READ_BYPASS_EN
    do_write(32'h30, 32'h55, 1'b1);
    do_read(32'h30, 1'b0, 32'h0, RL, "bypass");
    chk("bypass_word0", BW'(read_data[31:0]), BW'(32'h55));
    wait_idle();
`endif

    // Fill the buffer back-to-back, stall a fifth write, and watch in-order commits.
    for (int k = 0; k < 4; k++) old[k] = model[k];
    old[4] = model[15];
    a0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      do_write(32'(4 * k), 32'hA0 + 32'(k), 1'b1);
      chk($sformatf("wr%0d_cycle", k), BW'(cyc - a0), BW'(k));
    end
    chk("wbfull_after4", BW'(wb_full), BW'(1));
    do_write(32'h3C, 32'hA4, 1'b1);
    chk("wr4_cycle", BW'(cyc - a0), BW'(WL + 1));
    chk("commit0", BW'(dut.mem[0]), BW'(32'hA0));
    for (int k = 1; k < 4; k++) begin
      wait_cyc(a0 + int'(WL) * (k + 1) - 1);
      chk($sformatf("commit%0d_before", k), BW'(dut.mem[k]), BW'(old[k]));
      wait_cyc(a0 + int'(WL) * (k + 1));
      chk($sformatf("commit%0d_after", k), BW'(dut.mem[k]), BW'(32'hA0 + 32'(k)));
    end
    wait_cyc(a0 + 5 * int'(WL) - 1);
    chk("commit4_before", BW'(dut.mem[15]), BW'(old[4]));
    wait_cyc(a0 + 5 * int'(WL));
    chk("commit4_after", BW'(dut.mem[15]), BW'(32'hA4));
    wait_idle();

    // Reset in the middle of a store-miss read: merge word must not reach memory.
    address = 32'h60; wdata = 32'hDEAD; mwt = 1'b1; read_miss = 1'b1;
    a0 = cyc + 1;
    wait_cyc(a0 + 10);
    rst_n = 1'b0;
    #1 check_outputs_zero("midread_reset");
    read_miss = 1'b0; mwt = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    wait_cyc(cyc + 30);
    chk("midread_mem24", BW'(dut.mem[24]), BW'(model[24]));

    // Reset in the middle of a commit: the buffered word is discarded.
    do_write(32'h64, 32'hF00D, 1'b0);
    a0 = cyc;
    wait_cyc(a0 + 10);
    rst_n = 1'b0;
    #1 chk("midcommit_busy", BW'(busy), '0);
    chk("midcommit_wbfull", BW'(wb_full), '0);
    @(negedge clk) rst_n = 1'b1;
    wait_cyc(cyc + 30);
    chk("midcommit_mem25", BW'(dut.mem[25]), BW'(model[25]));

    do_read(32'h60, 1'b0, 32'h0, RL, "post_reset");
    wait_idle();
    chk("scoreboard_empty", BW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
